// File: rtl/aardvark_pkg.sv
// Shared widths, fetch FSM encoding and immediate helpers for the aardvark core.
package aardvark_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;
    localparam int JIMM_W  = 5;
    localparam int BOFF_W  = 2;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t FETCH = 2'd1;
    localparam fetch_state_t HOLD  = 2'd2;

    function automatic logic [PC_W-1:0] sext_branch(input logic [BOFF_W-1:0] off);
        return {{(PC_W-BOFF_W){off[BOFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection: sequential increment plus jump/branch redirect target.
module fetch_pc_next
    import aardvark_pkg::*;
(
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic [PC_W-1:0]   instr_pc,
    input  logic              jump_en,
    input  logic [JIMM_W-1:0] jump_target,
    input  logic              branch_en,
    input  logic [BOFF_W-1:0] branch_offset,
    output logic [PC_W-1:0]   seq_pc,
    output logic [PC_W-1:0]   target_pc,
    output logic              redirect
);

    assign seq_pc   = fetch_pc + PC_W'(1);
    assign redirect = jump_en | branch_en;

    // Jump stays within the current 32-byte region; it beats a simultaneous branch.
    always_comb begin
        target_pc = instr_pc + PC_W'(1) + sext_branch(branch_offset);
        if (jump_en) begin
            target_pc = {instr_pc[PC_W-1:JIMM_W], jump_target};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage with a one-entry holding register.
module instruction_fetch
    import aardvark_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [JIMM_W-1:0]  jump_target,
    input  logic               branch_en,
    input  logic [BOFF_W-1:0]  branch_offset,
    output logic [PC_W-1:0]    instr_pc
);

    fetch_state_t     state;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  target_pc;
    logic             redirect;

    fetch_pc_next u_pc_next (
        .fetch_pc      (fetch_pc),
        .instr_pc      (instr_pc),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .seq_pc        (seq_pc),
        .target_pc     (target_pc),
        .redirect      (redirect)
    );

    // Decoded from state so a reset drops the request in the same cycle.
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            instr_pc  <= '0;
            instr_out <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    // A redirect wins over a completing read, whose data is dropped.
                    if (redirect) begin
                        fetch_pc <= target_pc;
                    end else if (imem_ack) begin
                        instr_out <= imem_rdata;
                        instr_pc  <= fetch_pc;
                        fetch_pc  <= seq_pc;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                        state    <= FETCH;
                    end else if (instr_ready && !stall) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, directed redirects, random run.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       stall;
    logic       jump_en;
    logic [4:0] jump_target;
    logic       branch_en;
    logic [1:0] branch_offset;
    logic [7:0] instr_pc;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a PC, the held instruction and whether one is held.
    int m_started, m_valid, m_pc, m_ipc, m_iout;

    typedef struct {
        logic       ack;
        logic [7:0] rdata;
        logic       ready;
        logic       stl;
        logic       j;
        logic [4:0] jt;
        logic       b;
        logic [1:0] bo;
        logic [7:0] eaddr;
        logic       ereq;
        logic       evalid;
        logic [7:0] eout;
        logic [7:0] epc;
    } vec_t;

    vec_t vecs[18];

    instruction_fetch #(.RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input int eaddr, input int ereq,
                               input int evalid, input int eout, input int epc);
        checkField({tag, ".imem_addr"},   int'(imem_addr),   eaddr);
        checkField({tag, ".imem_req"},    int'(imem_req),    ereq);
        checkField({tag, ".instr_valid"}, int'(instr_valid), evalid);
        checkField({tag, ".instr_out"},   int'(instr_out),   eout);
        checkField({tag, ".instr_pc"},    int'(instr_pc),    epc);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_pc, (m_started != 0 && m_valid == 0) ? 1 : 0, m_valid, m_iout, m_ipc);
    endtask

    task automatic modelReset();
        m_started = 0; m_valid = 0; m_pc = 0; m_ipc = 0; m_iout = 0;
    endtask

    task automatic modelStep(input int ack, input int rdata, input int ready, input int stl,
                             input int j, input int jt, input int b, input int bo);
        int off;
        off = (bo >= 2) ? bo - 4 : bo;
        if (m_started == 0) begin
            m_started = 1;
        end else if (j != 0) begin
            m_pc = (m_ipc / 32) * 32 + jt;
            m_valid = 0;
        end else if (b != 0) begin
            m_pc = (m_ipc + 1 + off + 256) % 256;
            m_valid = 0;
        end else if (m_valid == 0) begin
            if (ack != 0) begin
                m_iout = rdata;
                m_ipc = m_pc;
                m_pc = (m_pc + 1) % 256;
                m_valid = 1;
            end
        end else if (ready != 0 && stl == 0) begin
            m_valid = 0;
        end
    endtask

    // Inputs are driven at the falling edge; outputs are compared at the next falling edge.
    task automatic applyStimulus(input logic ack, input logic [7:0] rd, input logic rdy,
                                 input logic stl, input logic j, input logic [4:0] jt,
                                 input logic b, input logic [1:0] bo);
        imem_ack = ack; imem_rdata = rd; instr_ready = rdy; stall = stl;
        jump_en = j; jump_target = jt; branch_en = b; branch_offset = bo;
        @(posedge clk);
        modelStep(int'(ack), int'(rd), int'(rdy), int'(stl), int'(j), int'(jt), int'(b), int'(bo));
        @(negedge clk);
    endtask

    task automatic stepChk(input string tag, input logic ack, input logic [7:0] rd,
                           input logic rdy, input logic stl, input logic j,
                           input logic [4:0] jt, input logic b, input logic [1:0] bo);
        applyStimulus(ack, rd, rdy, stl, j, jt, b, bo);
        checkModel(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ack = 0; imem_rdata = 0; instr_ready = 0; stall = 0;
        jump_en = 0; jump_target = 0; branch_en = 0; branch_offset = 0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 8'h00, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ack = 0; imem_rdata = 0; instr_ready = 0; stall = 0;
        jump_en = 0; jump_target = 0; branch_en = 0; branch_offset = 0;

        //            ack rdata  rdy stl j  jt     b  bo     addr   req vld out    pc
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h01, 1'b1, 1'b0, 8'hA5, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b1, 2'b10, 8'hFF, 1'b1, 1'b0, 8'hA5, 8'h00};
        vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h3C, 8'hFF};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 8'h3C, 8'hFF};
        vecs[11] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 5'h1C, 1'b0, 2'b00, 8'hFC, 1'b1, 1'b0, 8'h3C, 8'hFF};
        vecs[12] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'hFD, 1'b0, 1'b1, 8'h22, 8'hFC};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 2'b00, 8'hFD, 1'b0, 1'b1, 8'h22, 8'hFC};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 2'b01, 8'hFE, 1'b1, 1'b0, 8'h22, 8'hFC};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'h03, 1'b1, 2'b00, 8'hE3, 1'b1, 1'b0, 8'h22, 8'hFC};
        vecs[16] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 8'hE4, 1'b0, 1'b1, 8'h55, 8'hE3};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b1, 2'b10, 8'hE2, 1'b1, 1'b0, 8'h55, 8'hE3};

        doReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].stl,
                          vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bo);
            checkOutput($sformatf("vec%0d", i), vecs[i].eaddr, vecs[i].ereq,
                        vecs[i].evalid, vecs[i].eout, vecs[i].epc);
        end

        // Walk to instr_pc=0x10 for the negative branch, then up to 0x47 for the jump.
        doReset();
        stepChk("seq.idle",   0, 8'h00, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.f00",    1, 8'h01, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.j10",    0, 8'h00, 0, 0, 1, 5'h10, 0, 2'b00);
        stepChk("seq.f10",    1, 8'h02, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.b0f",    0, 8'h00, 0, 0, 0, 5'h00, 1, 2'b10);
        checkField("branch_target_0f", int'(imem_addr), 8'h0F);
        stepChk("seq.f0f",    1, 8'h03, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.j1f",    0, 8'h00, 0, 0, 1, 5'h1F, 0, 2'b00);
        stepChk("seq.f1f",    1, 8'h04, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.rdy",    0, 8'h00, 1, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.f20",    1, 8'h05, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.j3f",    0, 8'h00, 0, 0, 1, 5'h1F, 0, 2'b00);
        stepChk("seq.f3f",    1, 8'h06, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.rdy2",   0, 8'h00, 1, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.f40",    1, 8'h07, 0, 0, 0, 5'h00, 0, 2'b00);
        stepChk("seq.j47",    0, 8'h00, 0, 0, 1, 5'h07, 0, 2'b00);
        stepChk("seq.f47",    1, 8'h08, 0, 0, 0, 5'h00, 0, 2'b00);
        checkField("instr_pc_47", int'(instr_pc), 8'h47);
        stepChk("seq.j5c",    0, 8'h00, 0, 0, 1, 5'h1C, 0, 2'b00);
        checkField("jump_target_5c", int'(imem_addr), 8'h5C);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic ack, rdy, stl, j, b;
            ack = (m_started != 0 && m_valid == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            rdy = ($urandom_range(0, 2) != 0);
            stl = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 9) == 0);
            b   = ($urandom_range(0, 9) == 0);
            stepChk("rand", ack, 8'($urandom), rdy, stl, j, 5'($urandom), b, 2'($urandom));
        end

        // Reset in the middle of an outstanding fetch.
        begin
            int budget = 0;
            while (!(m_started != 0 && m_valid == 0) && budget < 10) begin
                stepChk("drain", 0, 8'h00, 1, 0, 0, 5'h00, 0, 2'b00);
                budget++;
            end
            checkField("reach_fetch", (budget < 10) ? 1 : 0, 1);
        end
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        #1;
        checkField("reset_drops_req", int'(imem_req), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        stepChk("idle_ignores", 1, 8'hEE, 0, 0, 1, 5'h1F, 0, 2'b00);
        stepChk("stale_ack",    0, 8'h00, 0, 0, 0, 5'h00, 0, 2'b00);
        checkField("stale_ack_valid", int'(instr_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, the address fetched first after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_addr  output  8  the instruction memory address, equal to fetch_pc.
REQ-005 SHALL have port imem_req  output  1  the instruction memory read request.
REQ-006 SHALL have port imem_ack  input  1  read complete; imem_rdata valid in the same cycle.
REQ-007 SHALL have port imem_rdata  input  8  the instruction word from memory.
REQ-008 SHALL have port instr_out  output  8  the held instruction, fed to the decoder's instruction input.
REQ-009 SHALL have port instr_valid  output  1  instr_out holds a valid instruction.
REQ-010 SHALL have port instr_ready  input  1  downstream consumes instr_out this cycle.
REQ-011 SHALL have port stall  input  1  freeze the pipeline advance.
REQ-012 SHALL have port jump_en  input  1  the jump redirect request.
REQ-013 SHALL have port jump_target  input  5  the jump immediate (instruction bits 4:0).
REQ-014 SHALL have port branch_en  input  1  the branch redirect request.
REQ-015 SHALL have port branch_offset  input  2  the signed branch immediate (instruction bits 3:2).
REQ-016 SHALL have port instr_pc  output  8  the address of the instruction in instr_out.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH and HOLD; IDLE lasts exactly one cycle after reset release, then moves to FETCH.
REQ-018 SHALL drive imem_req=1 only in FETCH, with imem_addr=fetch_pc stable until imem_ack.
REQ-019 SHALL, in FETCH with imem_ack=1 and no redirect, latch imem_rdata into instr_out, fetch_pc into instr_pc, set fetch_pc to fetch_pc+1 (mod 256, so 8'hFF wraps to 8'h00), and go to HOLD.
REQ-020 SHALL assert instr_valid only in HOLD; with a zero-wait memory, instr_valid rises in the cycle after the imem_ack.
REQ-021 SHALL, in HOLD, go to FETCH when instr_ready=1 and stall=0, and otherwise stay in HOLD with instr_out unchanged.
REQ-022 SHALL, in FETCH, keep waiting indefinitely for imem_ack regardless of stall; stall affects only the HOLD-to-FETCH advance.
REQ-023 SHALL compute the jump target as {instr_pc[7:5], jump_target}.
REQ-024 SHALL compute the branch target as instr_pc + 1 + sign-extended branch_offset (range -2..+1), mod 256.
REQ-025 SHALL give jump_en priority over branch_en when both are asserted.
REQ-026 SHALL, on any redirect in FETCH or HOLD: load fetch_pc with the target, clear instr_valid, and go to FETCH in the next cycle.
REQ-027 SHALL, on a redirect coinciding with imem_ack, discard imem_rdata, leave instr_out unchanged and not increment fetch_pc.
REQ-028 SHALL give a redirect priority over stall.
REQ-029 SHALL ignore redirect inputs in IDLE.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=IDLE, fetch_pc=RESET_PC, instr_pc=8'h00, instr_out=8'h00, instr_valid=0 and imem_req=0.
REQ-031 SHALL, when reset is asserted mid-fetch, drop imem_req immediately and ignore any later imem_ack until a new request is issued.

Structure
REQ-032 SHALL take PC_W=8, INSTR_W=8, JIMM_W=5 and the fetch_state_t encoding from the shared package aardvark_pkg.
REQ-033 SHALL place the combinational next-PC selection (increment, jump, branch) in the single sub-module fetch_pc_next.

Verification
REQ-034 Reset release with RESET_PC=8'h00 and zero-wait memory returning 8'hA5 SHALL give imem_addr=00, then instr_out=A5, instr_valid=1, instr_pc=00.
REQ-035 instr_ready=0 held for 5 cycles SHALL keep instr_out and instr_valid stable; the next fetch SHALL start at addr 01 one cycle after instr_ready=1.
REQ-036 instr_pc=8'h47 with jump_en=1 and jump_target=5'h1C SHALL make the next imem_addr 8'h5C.
REQ-037 instr_pc=8'h10 with branch_en=1 and offset=2'b10 SHALL make the next imem_addr 8'h0F; branch_en and jump_en together SHALL make the jump win.
REQ-038 A fetch at 8'hFF SHALL make the following fetch address 8'h00.
REQ-039 A redirect in the same cycle as imem_ack SHALL discard the data; a stall with instr_ready=1 SHALL hold; rst_n low mid-FETCH SHALL drop imem_req within the same cycle.
